// File: rtl/parking_pkg.sv
// Shared types and helpers for the multi-gate parking occupancy tracker.
package parking_pkg;

    localparam int MAX_GATES = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EN_OUT  = 3'd1,
        EN_BOTH = 3'd2,
        EN_IN   = 3'd3,
        EX_IN   = 3'd4,
        EX_BOTH = 3'd5,
        EX_OUT  = 3'd6,
        ABORT   = 3'd7
    } gate_state_t;

    // Number of set bits in a gate vector padded out to MAX_GATES.
    function automatic logic [3:0] popcount(input logic [MAX_GATES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < MAX_GATES; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One gate's entry/exit sequence tracker; emits registered one-cycle
// completion pulses on the edge that samples the final 00.
module parking_gate_fsm
    import parking_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic outer,
    input  logic inner,
    output logic enter_done,
    output logic exit_done
);

    gate_state_t state_reg;
    gate_state_t state_next;
    logic        enter_next;
    logic        exit_next;
    logic [1:0]  sensors;

    assign sensors = {outer, inner};

    always_comb begin
        state_next = state_reg;
        enter_next = 1'b0;
        exit_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                case (sensors)
                    2'b10:   state_next = EN_OUT;
                    2'b01:   state_next = EX_IN;
                    2'b11:   state_next = ABORT;
                    default: state_next = IDLE;
                endcase
            end
            EN_OUT: begin
                case (sensors)
                    2'b11:   state_next = EN_BOTH;
                    2'b01:   state_next = ABORT;
                    2'b00:   state_next = IDLE;
                    default: state_next = EN_OUT;
                endcase
            end
            EN_BOTH: begin
                case (sensors)
                    2'b01:   state_next = EN_IN;
                    2'b10:   state_next = EN_OUT;
                    2'b00:   state_next = ABORT;
                    default: state_next = EN_BOTH;
                endcase
            end
            EN_IN: begin
                case (sensors)
                    2'b00: begin
                        state_next = IDLE;
                        enter_next = 1'b1;
                    end
                    2'b11:   state_next = EN_BOTH;
                    2'b10:   state_next = ABORT;
                    default: state_next = EN_IN;
                endcase
            end
            // Exit path is the entry path with the two beams swapped.
            EX_IN: begin
                case (sensors)
                    2'b11:   state_next = EX_BOTH;
                    2'b10:   state_next = ABORT;
                    2'b00:   state_next = IDLE;
                    default: state_next = EX_IN;
                endcase
            end
            EX_BOTH: begin
                case (sensors)
                    2'b10:   state_next = EX_OUT;
                    2'b01:   state_next = EX_IN;
                    2'b00:   state_next = ABORT;
                    default: state_next = EX_BOTH;
                endcase
            end
            EX_OUT: begin
                case (sensors)
                    2'b00: begin
                        state_next = IDLE;
                        exit_next  = 1'b1;
                    end
                    2'b11:   state_next = EX_BOTH;
                    2'b01:   state_next = ABORT;
                    default: state_next = EX_OUT;
                endcase
            end
            ABORT: begin
                if (sensors == 2'b00) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            enter_done <= 1'b0;
            exit_done  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            enter_done <= enter_next;
            exit_done  <= exit_next;
        end
    end

endmodule

// File: rtl/parking_occupancy_multi.sv
// Multi-gate occupancy tracker: per-gate sequence FSMs feed a shared
// saturating counter with full/empty status and sticky saturation flags.
module parking_occupancy_multi
    import parking_pkg::*;
#(
    parameter int N_GATES  = 2,
    parameter int CAPACITY = 16,
    parameter int CW       = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_GATES-1:0] outer,
    input  logic [N_GATES-1:0] inner,
    input  logic               clr_flags,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic [N_GATES-1:0] car_in,
    output logic [N_GATES-1:0] car_out,
    output logic               overflow,
    output logic               underflow
);

    localparam int SW = CW + 4;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    logic [N_GATES-1:0]     enter_done;
    logic [N_GATES-1:0]     exit_done;
    logic [MAX_GATES-1:0]   enter_vec;
    logic [MAX_GATES-1:0]   exit_vec;
    logic signed [SW-1:0]   net;
    logic signed [SW-1:0]   sum;
    logic [CW-1:0]          count_reg;
    logic [CW-1:0]          count_next;
    logic                   ovf_now;
    logic                   unf_now;
    logic                   overflow_reg;
    logic                   underflow_reg;

    generate
        for (genvar gi = 0; gi < N_GATES; gi++) begin : gen_gate
            parking_gate_fsm u_gate (
                .clk        (clk),
                .reset      (reset),
                .outer      (outer[gi]),
                .inner      (inner[gi]),
                .enter_done (enter_done[gi]),
                .exit_done  (exit_done[gi])
            );
        end
    endgenerate

    always_comb begin
        enter_vec = '0;
        exit_vec  = '0;
        enter_vec[N_GATES-1:0] = enter_done;
        exit_vec[N_GATES-1:0]  = exit_done;
    end

    // The pulses are high in the cycle after the completing edge, so the
    // clamped total is presented combinationally from them; count_reg then
    // absorbs the same total on the following edge, when the pulses drop.
    always_comb begin
        net        = signed'(SW'(popcount(enter_vec))) - signed'(SW'(popcount(exit_vec)));
        sum        = signed'(SW'(count_reg)) + net;
        ovf_now    = 1'b0;
        unf_now    = 1'b0;
        count_next = sum[CW-1:0];
        if (sum < 0) begin
            count_next = '0;
            unf_now    = 1'b1;
        end else if (sum > CAP_S) begin
            count_next = CW'(CAPACITY);
            ovf_now    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            overflow_reg  <= ovf_now | (overflow_reg & ~clr_flags);
            underflow_reg <= unf_now | (underflow_reg & ~clr_flags);
        end
    end

    assign count     = count_next;
    assign full      = (count_next == CW'(CAPACITY));
    assign empty     = (count_next == '0);
    assign car_in    = enter_done;
    assign car_out   = exit_done;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_parking_occupancy_multi.sv
// Directed bench for parking_occupancy_multi with two gates and capacity 16.
module tb_parking_occupancy_multi;

    logic       clk;
    logic       reset;
    logic [1:0] outer;
    logic [1:0] inner;
    logic       clr_flags;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic [1:0] car_in;
    logic [1:0] car_out;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    parking_occupancy_multi #(
        .N_GATES  (2),
        .CAPACITY (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .outer     (outer),
        .inner     (inner),
        .clr_flags (clr_flags),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .car_in    (car_in),
        .car_out   (car_out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply (o,i) for gate0 and gate1, clock once, settle 1 ns after the edge.
    task automatic drive(input logic [1:0] g0, input logic [1:0] g1);
        outer = {g1[1], g0[1]};
        inner = {g1[0], g0[0]};
        @(posedge clk);
        #1;
    endtask

    task automatic do_entry();
        drive(2'b10, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b01, 2'b00);
        drive(2'b00, 2'b00);
        $display("entry gate0 car_in=%b count=%0d", car_in, count);
    endtask

    task automatic do_exit();
        drive(2'b00, 2'b01);
        drive(2'b00, 2'b11);
        drive(2'b00, 2'b10);
        drive(2'b00, 2'b00);
        $display("exit gate1 car_out=%b count=%0d", car_out, count);
    endtask

    task automatic test_reset();
        reset = 1'b1; clr_flags = 1'b0; outer = '0; inner = '0;
        @(posedge clk); @(posedge clk); #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_status got full=%b empty=%b exp full=0 empty=1", full, empty); end
        total++; if (car_in !== 2'b00 || car_out !== 2'b00) begin bad++; $display("FAIL reset_pulses got in=%b out=%b exp 00 00", car_in, car_out); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0 0", overflow, underflow); end
        reset = 1'b0;
        drive(2'b00, 2'b00);
        $display("reset released count=%0d", count);
    endtask

    task automatic test_entry();
        drive(2'b10, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b01, 2'b00);
        total++; if (car_in !== 2'b00 || count !== 5'd0) begin bad++; $display("FAIL entry_early got in=%b count=%0d exp 00 0", car_in, count); end
        drive(2'b00, 2'b00);
        total++; if (car_in !== 2'b01) begin bad++; $display("FAIL entry_pulse got=%b exp=01", car_in); end
        total++; if (count !== 5'd1 || empty !== 1'b0) begin bad++; $display("FAIL entry_count got count=%0d empty=%b exp 1 0", count, empty); end
        total++; if (car_out !== 2'b00 || overflow !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL entry_side got out=%b ovf=%b full=%b exp 00 0 0", car_out, overflow, full); end
        drive(2'b00, 2'b00);
        total++; if (car_in !== 2'b00 || count !== 5'd1) begin bad++; $display("FAIL entry_after got in=%b count=%0d exp 00 1", car_in, count); end
        $display("entry gate0 count=%0d", count);
    endtask

    task automatic test_exit_and_pedestrian();
        drive(2'b00, 2'b01);
        drive(2'b00, 2'b11);
        drive(2'b00, 2'b10);
        drive(2'b00, 2'b00);
        total++; if (car_out !== 2'b10) begin bad++; $display("FAIL exit_pulse got=%b exp=10", car_out); end
        total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL exit_count got count=%0d empty=%b exp 0 1", count, empty); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL exit_noflag got=%b exp=0", underflow); end
        $display("exit gate1 count=%0d", count);
        drive(2'b10, 2'b00);
        drive(2'b01, 2'b00);
        drive(2'b00, 2'b00);
        total++; if (car_in !== 2'b00 || car_out !== 2'b00 || count !== 5'd0) begin bad++; $display("FAIL pedestrian got in=%b out=%b count=%0d exp 00 00 0", car_in, car_out, count); end
        drive(2'b00, 2'b00);
        total++; if (car_in !== 2'b00 || count !== 5'd0) begin bad++; $display("FAIL pedestrian_after got in=%b count=%0d exp 00 0", car_in, count); end
        $display("pedestrian gate0 count=%0d", count);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) do_entry();
        total++; if (count !== 5'd5) begin bad++; $display("FAIL fill5 got=%0d exp=5", count); end
        drive(2'b10, 2'b01);
        drive(2'b11, 2'b11);
        drive(2'b01, 2'b10);
        drive(2'b00, 2'b00);
        total++; if (car_in !== 2'b01 || car_out !== 2'b10) begin bad++; $display("FAIL simul_pulses got in=%b out=%b exp 01 10", car_in, car_out); end
        total++; if (count !== 5'd5) begin bad++; $display("FAIL simul_count got=%0d exp=5", count); end
        drive(2'b00, 2'b00);
        total++; if (count !== 5'd5 || overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL simul_after got count=%0d ovf=%b unf=%b exp 5 0 0", count, overflow, underflow); end
        $display("simultaneous entry/exit count=%0d", count);
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 11; k++) do_entry();
        total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL full got count=%0d full=%b exp 16 1", count, full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_noflag got=%b exp=0", overflow); end
        do_entry();
        total++; if (car_in !== 2'b01) begin bad++; $display("FAIL sat_pulse got=%b exp=01", car_in); end
        total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL sat_count got count=%0d full=%b exp 16 1", count, full); end
        drive(2'b00, 2'b00);
        total++; if (overflow !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_set got ovf=%b count=%0d exp 1 16", overflow, count); end
        clr_flags = 1'b1;
        drive(2'b00, 2'b00);
        clr_flags = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        $display("overflow cleared count=%0d", count);
    endtask

    task automatic test_underflow();
        for (int k = 0; k < 16; k++) do_exit();
        total++; if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0) begin bad++; $display("FAIL drain got count=%0d empty=%b unf=%b exp 0 1 0", count, empty, underflow); end
        do_exit();
        total++; if (car_out !== 2'b10 || count !== 5'd0) begin bad++; $display("FAIL unf_pulse got out=%b count=%0d exp 10 0", car_out, count); end
        // clr_flags lands on the same edge that records the violation.
        clr_flags = 1'b1;
        drive(2'b00, 2'b00);
        clr_flags = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_set_wins got=%b exp=1", underflow); end
        drive(2'b00, 2'b00);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_sticky got=%b exp=1", underflow); end
        clr_flags = 1'b1;
        drive(2'b00, 2'b00);
        clr_flags = 1'b0;
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b exp=0", underflow); end
        drive(2'b10, 2'b01);
        drive(2'b11, 2'b11);
        drive(2'b01, 2'b10);
        drive(2'b00, 2'b00);
        total++; if (car_in !== 2'b01 || car_out !== 2'b10 || count !== 5'd0) begin bad++; $display("FAIL zero_simul got in=%b out=%b count=%0d exp 01 10 0", car_in, car_out, count); end
        drive(2'b00, 2'b00);
        total++; if (underflow !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL zero_simul_flag got unf=%b count=%0d exp 0 0", underflow, count); end
        $display("underflow checks count=%0d", count);
    endtask

    task automatic test_reset_mid();
        do_entry();
        total++; if (count !== 5'd1) begin bad++; $display("FAIL pre_reset got=%0d exp=1", count); end
        drive(2'b10, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b01, 2'b00);
        reset = 1'b1;
        drive(2'b01, 2'b00);
        reset = 1'b0;
        total++; if (count !== 5'd0 || car_in !== 2'b00 || empty !== 1'b1) begin bad++; $display("FAIL mid_reset got count=%0d in=%b empty=%b exp 0 00 1", count, car_in, empty); end
        drive(2'b00, 2'b00);
        total++; if (car_in !== 2'b00 || car_out !== 2'b00 || count !== 5'd0) begin bad++; $display("FAIL post_reset_00 got in=%b out=%b count=%0d exp 00 00 0", car_in, car_out, count); end
        do_entry();
        total++; if (car_in !== 2'b01 || count !== 5'd1) begin bad++; $display("FAIL post_reset_entry got in=%b count=%0d exp 01 1", car_in, count); end
        $display("reset mid-sequence count=%0d", count);
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit_and_pedestrian();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_multi.md
Name: parking_occupancy_multi

Overview:
- Next-generation parking-lot occupancy tracker. Supports N_GATES independent gates, each with an outer and an inner beam sensor.
- Each gate has its own entry/exit sequence FSM. A shared occupancy counter aggregates all gates and saturates at 0 and at a parametrised CAPACITY.
- Adds full/empty status, per-gate event pulses and sticky overflow/underflow flags. Sits between the sensor input synchronisers and the display/status logic.

Parameters:
- N_GATES, 2, number of gates (1..8).
- CAPACITY, 16, maximum occupancy (1..255).
- CW, $clog2(CAPACITY+1), count width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- outer  in  N_GATES  outer-sensor blocked, one bit per gate (already synchronised)
- inner  in  N_GATES  inner-sensor blocked, one bit per gate
- clr_flags  in  1  clears the overflow and underflow flags
- count  out  CW  current occupancy
- full  out  1  count == CAPACITY
- empty  out  1  count == 0
- car_in  out  N_GATES  one-cycle pulse per gate on completed entry
- car_out  out  N_GATES  one-cycle pulse per gate on completed exit
- overflow  out  1  sticky: an entry was lost to saturation
- underflow  out  1  sticky: an exit was lost at zero

Behaviour:
- Reset (synchronous, active-high): count=0, all gate FSMs=IDLE, car_in=car_out=0, overflow=underflow=0, full=0, empty=1. Reset wins over every other event.
- Sensor encoding per gate is (o,i). The gate FSM states are IDLE, EN_OUT, EN_BOTH, EN_IN, EX_IN, EX_BOTH, EX_OUT, ABORT.
- IDLE: 10->EN_OUT; 01->EX_IN; 11->ABORT; 00 stays.
- EN_OUT: 11->EN_BOTH; 01->ABORT (pedestrian); 00->IDLE; 10 stays.
- EN_BOTH: 01->EN_IN; 10->EN_OUT (back-out); 00->ABORT; 11 stays.
- EN_IN: 00->IDLE and assert car_in[g]; 11->EN_BOTH; 10->ABORT; 01 stays.
- Exit path mirrors entry with o and i swapped: EX_IN->EX_BOTH->EX_OUT. EX_OUT on 00->IDLE asserts car_out[g].
- ABORT: 00->IDLE with no pulse; any other input stays.
- car_in/car_out are registered pulses. They are high for exactly the one cycle after the edge that sampled the completing 00.
- Counter update uses the same completing edge, so count reflects the event in the same cycle the pulse is high.
- Arithmetic: net = popcount(completing entries) - popcount(completing exits), computed signed at CW+4 bits.
- count_next = clamp(count+net, 0, CAPACITY). Simultaneous entry and exit on different gates cancel.
- overflow sets if count+net > CAPACITY; underflow sets if count+net < 0. Both stay set until reset or clr_flags.
- If clr_flags and a new violation occur in the same cycle, set wins.
- full and empty are combinational from count.
- Pulses (car_in/car_out) fire even when the counter saturates.
- Reset asserted mid-sequence returns the FSM to IDLE. A partially traversed gate after reset needs 00 followed by a full sequence to count.

Decomposition:
- Package parking_pkg: gate_state_t enum (8 states, 3 bits) and MAX_GATES=8.
- Sub-module parking_gate_fsm (one instance per gate, generate loop).
  - Ports: clk, reset, outer, inner, enter_done, exit_done.
  - Contains the FSM and the registered pulses.
- The top module holds the popcount, the clamp, the flags and the counter.

Test Plan:
- Gate0 drives 10,11,01,00 -> car_in[0] pulses 1 cycle; count 0->1; empty falls; no other outputs change.
- Gate1 drives 01,11,10,00 from count=1 -> car_out[1] pulses; count=0; empty=1. Then gate0 drives 10,01,00 (pedestrian) -> no pulse; count stays 0.
- Gate0 entry and gate1 exit complete on the same edge at count=5 -> both pulse; count stays 5; no flags.
- CAPACITY=16: run 16 entries -> full=1. Run a 17th -> car_in pulses, count stays 16, overflow=1. Pulse clr_flags -> overflow=0.
- count=0: complete an exit -> car_out pulses, count stays 0, underflow=1. Issue a simultaneous entry and exit -> count=0, and underflow is not newly set.
- Gate0 reaches EN_IN, then reset is asserted for 1 cycle with inputs held at 01 -> count=0 and FSM=IDLE. Next 00 produces no pulse.
